alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
Multi-cycle instruction sequencer for the 16-bit ALU / register-file / immediate-mux datapath. It accepts one 16-bit instruction at a time over a valid/ready handshake and decodes it. It then drives the datapath control fields (FullOp, Rdest, Rsrc, imm, ctrlMuxB, Write) through fetch, decode, execute, memory and writeback phases. It also latches the ALU flags and counts retired instructions.

Parameters:
MEM_TIMEOUT, 15, max cycles in MEM waiting for mem_ack before abort (1..255)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
instr_valid  in  1  instruction available
instr  in  16  [15:12]=op, [11:8]=Rdest, [7:4]=ext, [3:0]=Rsrc; imm8=[7:0]
instr_ready  out  1  sequencer can accept instruction
alu_flags  in  5  Flags from ALU (combinational, valid in EXEC)
mem_ack  in  1  memory completes the access
FullOp  out  8  ALU opcode
Rdest  out  4  destination / A register index
Rsrc  out  4  source / B register index
imm  out  16  immediate to B mux
ctrlMuxB  out  1  1 = imm on B, 0 = register
Write  out  1  regfile write enable (one-cycle pulse)
wb_sel  out  1  0 = writeback from ALU, 1 = from memory
mem_req  out  1  memory access request (level)
mem_we  out  1  1 = store, valid while mem_req
flags_q  out  5  latched ALU flags
illegal  out  1  one-cycle pulse: undecodable op or mem timeout
retired  out  CNT_W  instructions completed (wraps)

Behaviour:
- Reset (rst low, async): state FETCH. All outputs 0 except instr_ready=1. flags_q=0, retired=0, timeout counter=0.
- States: FETCH, DECODE, EXEC, MEM, WB.
- FETCH: instr_ready=1. On instr_valid&&instr_ready, latch instr and go to DECODE. Otherwise stay.
- DECODE: register the decoded fields. FullOp, Rdest, Rsrc, imm and ctrlMuxB become valid at the next edge and hold until the next DECODE.
- Decode rules:
  - op==0000, register form: FullOp={0000,ext}, ctrlMuxB=0. Legal ext values: 0000 WAIT, 0001, 0010, 0011, 0101, 0110, 0111, 1001, 1010, 1011, 1101, 1110.
  - op in {0101,1001,1011,0111}, ADDI/SUBI/CMPI/ADDCI: FullOp={op,0000}, imm=sign-extended imm8, ctrlMuxB=1.
  - op in {0110,1110,0010}, ADDUI/ADDCUI/NOT: FullOp={op,0000}, imm=zero-extended imm8, ctrlMuxB=1.
  - op==1000, shift: FullOp={1000,ext}. If ext[3:1]==000: ctrlMuxB=1, imm={12'b0,instr[3:0]}. Legal ext otherwise: 0100, 0110, 0010, with ctrlMuxB=0.
  - op==0100, ext==0000: LOAD. op==0100, ext==0100: STORE. FullOp={op,ext}, ctrlMuxB=0.
  - Anything else is illegal: pulse illegal and go to FETCH. retired is not incremented.
- EXEC: exactly 1 cycle with operands stable. At its end, flags_q<=alu_flags for all ALU ops except WAIT.
  - WAIT goes to FETCH with retired+1 and no Write.
  - CMP (0000_1011), CMPI (1011), CMPU (0000_1101) go to FETCH with retired+1 and no Write.
  - LOAD and STORE go to MEM.
  - All other ops go to WB.
- MEM: mem_req=1; mem_we=1 for STORE.
  - On mem_ack: LOAD goes to WB with wb_sel=1. STORE goes to FETCH with retired+1.
  - The timeout counter increments each MEM cycle. If it reaches MEM_TIMEOUT without mem_ack: drop mem_req, pulse illegal, go to FETCH, no retire.
  - mem_ack coinciding with the timeout cycle counts as success.
  - The counter clears on MEM entry.
- WB: Write=1 for one cycle, wb_sel held. Then go to FETCH with retired+1. wb_sel clears in FETCH.
- Latency: ALU op with write is 4 cycles from acceptance edge to FETCH re-entry, with Write in cycle 4. Compare/WAIT take 3 cycles. LOAD takes 4 + ack-wait cycles.
- instr_ready is 0 in every state except FETCH, so no back-to-back overlap. instr is ignored outside FETCH.
- retired wraps from all-ones to 0.
- Reset mid-operation aborts immediately: Write and mem_req drop asynchronously, and no partial retire occurs.

Decomposition:
- Package alu_seq_pkg: state enum; 4-bit major opcodes; 8-bit FullOp constants (ADD, ADDI, ..., LOAD, STORE, WAIT); helper function is_compare().
- Sub-module alu_seq_decode: combinational; instr -> {FullOp, imm, ctrlMuxB, is_load, is_store, no_write, legal}. The FSM and counters stay in alu_sequencer.

Test Plan:
- ADD r3,r5, instr=0x0355 -> after DECODE: FullOp=0x05, Rdest=3, Rsrc=5, ctrlMuxB=0. Write high in cycle 4 only, retired=1.
- ADDI r2,#-1, instr=0x52FF -> FullOp=0x50, imm=0xFFFF, ctrlMuxB=1. ADDUI, instr=0x62FF -> imm=0x00FF.
- CMP r1,r2, instr=0x01B2 with alu_flags=5'b10101 -> flags_q=5'b10101 after EXEC, Write never asserted, back in FETCH 3 cycles after accept.
- LOAD r4, instr=0x4402, mem_ack after 3 MEM cycles -> mem_req high 3 cycles, mem_we=0, then Write=1 with wb_sel=1. STORE, instr=0x4442 -> mem_we=1, no Write.
- LOAD with no mem_ack, MEM_TIMEOUT=15 -> mem_req drops after 15 cycles, illegal pulses once, retired unchanged. Illegal instr=0xF000 -> illegal pulse, back to FETCH.
- Assert rst low during MEM -> mem_req=0 and instr_ready=1 immediately. After release, the next instruction executes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and opcode constants for the ALU instruction sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_t;

    localparam logic [3:0] OP_REG    = 4'h0;
    localparam logic [3:0] OP_NOT    = 4'h2;
    localparam logic [3:0] OP_LDST   = 4'h4;
    localparam logic [3:0] OP_ADDI   = 4'h5;
    localparam logic [3:0] OP_ADDUI  = 4'h6;
    localparam logic [3:0] OP_ADDCI  = 4'h7;
    localparam logic [3:0] OP_SHIFT  = 4'h8;
    localparam logic [3:0] OP_SUBI   = 4'h9;
    localparam logic [3:0] OP_CMPI   = 4'hB;
    localparam logic [3:0] OP_ADDCUI = 4'hE;

    localparam logic [7:0] FOP_WAIT  = 8'h00;
    localparam logic [7:0] FOP_AND   = 8'h01;
    localparam logic [7:0] FOP_OR    = 8'h02;
    localparam logic [7:0] FOP_XOR   = 8'h03;
    localparam logic [7:0] FOP_ADD   = 8'h05;
    localparam logic [7:0] FOP_ADDU  = 8'h06;
    localparam logic [7:0] FOP_ADDC  = 8'h07;
    localparam logic [7:0] FOP_SUB   = 8'h09;
    localparam logic [7:0] FOP_SUBC  = 8'h0A;
    localparam logic [7:0] FOP_CMP   = 8'h0B;
    localparam logic [7:0] FOP_CMPU  = 8'h0D;
    localparam logic [7:0] FOP_ADDCU = 8'h0E;
    localparam logic [7:0] FOP_ADDI  = 8'h50;
    localparam logic [7:0] FOP_SUBI  = 8'h90;
    localparam logic [7:0] FOP_CMPI  = 8'hB0;
    localparam logic [7:0] FOP_LOAD  = 8'h40;
    localparam logic [7:0] FOP_STORE = 8'h44;

    function automatic logic is_compare(input logic [7:0] fop);
        return (fop == FOP_CMP) || (fop == FOP_CMPI) || (fop == FOP_CMPU);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake, datapath control and memory signals of the sequencer.
interface alu_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             instr_valid;
    logic [15:0]      instr;
    logic             instr_ready;
    logic [4:0]       alu_flags;
    logic             mem_ack;
    logic [7:0]       FullOp;
    logic [3:0]       Rdest;
    logic [3:0]       Rsrc;
    logic [15:0]      imm;
    logic             ctrlMuxB;
    logic             Write;
    logic             wb_sel;
    logic             mem_req;
    logic             mem_we;
    logic [4:0]       flags_q;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport slave (
        input  instr_valid, instr, alu_flags, mem_ack,
        output instr_ready, FullOp, Rdest, Rsrc, imm, ctrlMuxB, Write,
               wb_sel, mem_req, mem_we, flags_q, illegal, retired
    );

    modport master (
        output instr_valid, instr, alu_flags, mem_ack,
        input  instr_ready, FullOp, Rdest, Rsrc, imm, ctrlMuxB, Write,
               wb_sel, mem_req, mem_we, flags_q, illegal, retired
    );
endinterface

// File: rtl/alu_seq_decode.sv
// Combinational instruction decoder: instruction word to datapath control fields.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [15:0] instr,
    output logic [7:0]  FullOp,
    output logic [15:0] imm,
    output logic        ctrlMuxB,
    output logic        is_load,
    output logic        is_store,
    output logic        no_write,
    output logic        legal
);
    logic [3:0] op;
    logic [3:0] ext;
    logic [7:0] imm8;

    assign op   = instr[15:12];
    assign ext  = instr[7:4];
    assign imm8 = instr[7:0];

    always_comb begin
        FullOp   = '0;
        imm      = '0;
        ctrlMuxB = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        legal    = 1'b0;
        case (op)
            OP_REG: begin
                if (ext inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7,
                                4'h9, 4'hA, 4'hB, 4'hD, 4'hE}) begin
                    legal  = 1'b1;
                    FullOp = {op, ext};
                end
            end
            OP_ADDI, OP_SUBI, OP_CMPI, OP_ADDCI: begin
                legal    = 1'b1;
                FullOp   = {op, 4'h0};
                imm      = {{8{imm8[7]}}, imm8};
                ctrlMuxB = 1'b1;
            end
            OP_ADDUI, OP_ADDCUI, OP_NOT: begin
                legal    = 1'b1;
                FullOp   = {op, 4'h0};
                imm      = {8'h00, imm8};
                ctrlMuxB = 1'b1;
            end
            OP_SHIFT: begin
                FullOp = {op, ext};
                // Immediate shifts take the amount from the Rsrc field.
                if (ext[3:1] == 3'b000) begin
                    legal    = 1'b1;
                    ctrlMuxB = 1'b1;
                    imm      = {12'h000, instr[3:0]};
                end else if (ext inside {4'h2, 4'h4, 4'h6}) begin
                    legal = 1'b1;
                end
            end
            OP_LDST: begin
                FullOp = {op, ext};
                if (ext == 4'h0) begin
                    legal   = 1'b1;
                    is_load = 1'b1;
                end else if (ext == 4'h4) begin
                    legal    = 1'b1;
                    is_store = 1'b1;
                end
            end
            default: ;
        endcase
        no_write = legal && (FullOp == FOP_WAIT || is_compare(FullOp) || is_store);
    end
endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the ALU datapath controls.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic            clk,
    input  logic            rst,
    alu_sequencer_if.slave  bus
);
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [15:0]      instr_q;
    logic [7:0]       dec_fop;
    logic [15:0]      dec_imm;
    logic             dec_cmux, dec_load, dec_store, dec_nowr, dec_legal;
    logic [7:0]       fop_q;
    logic [3:0]       rdest_q, rsrc_q;
    logic [15:0]      imm_q;
    logic             cmux_q, load_q, store_q, nowr_q;
    logic [7:0]       tcnt;
    logic [4:0]       flags_r;
    logic [CNT_W-1:0] retired_q;
    logic             retire, timeout;

    alu_seq_decode u_decode (
        .instr    (instr_q),
        .FullOp   (dec_fop),
        .imm      (dec_imm),
        .ctrlMuxB (dec_cmux),
        .is_load  (dec_load),
        .is_store (dec_store),
        .no_write (dec_nowr),
        .legal    (dec_legal)
    );

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_FETCH:  if (bus.instr_valid) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = dec_legal ? ST_EXEC : ST_FETCH;
            ST_EXEC: begin
                if (load_q || store_q) begin
                    state_nxt = ST_MEM;
                end else if (nowr_q) begin
                    state_nxt = ST_FETCH;
                    retire    = 1'b1;
                end else begin
                    state_nxt = ST_WB;
                end
            end
            ST_MEM: begin
                // An ack in the final allowed cycle still wins over the timeout.
                if (bus.mem_ack) begin
                    state_nxt = load_q ? ST_WB : ST_FETCH;
                    retire    = !load_q;
                end else if (tcnt == TMO_LAST) begin
                    state_nxt = ST_FETCH;
                    timeout   = 1'b1;
                end
            end
            ST_WB: begin
                state_nxt = ST_FETCH;
                retire    = 1'b1;
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_FETCH;
            instr_q   <= '0;
            fop_q     <= '0;
            rdest_q   <= '0;
            rsrc_q    <= '0;
            imm_q     <= '0;
            cmux_q    <= 1'b0;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            nowr_q    <= 1'b0;
            tcnt      <= '0;
            flags_r   <= '0;
            retired_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_FETCH && bus.instr_valid) instr_q <= bus.instr;
            if (state == ST_DECODE && dec_legal) begin
                fop_q   <= dec_fop;
                rdest_q <= instr_q[11:8];
                rsrc_q  <= instr_q[3:0];
                imm_q   <= dec_imm;
                cmux_q  <= dec_cmux;
                load_q  <= dec_load;
                store_q <= dec_store;
                nowr_q  <= dec_nowr;
            end
            if (state == ST_EXEC && fop_q != FOP_WAIT && !load_q && !store_q)
                flags_r <= bus.alu_flags;
            tcnt <= (state == ST_MEM) ? tcnt + 8'd1 : '0;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign bus.instr_ready = (state == ST_FETCH);
    assign bus.Write       = (state == ST_WB);
    assign bus.wb_sel      = (state == ST_WB) && load_q;
    assign bus.mem_req     = (state == ST_MEM);
    assign bus.mem_we      = (state == ST_MEM) && store_q;
    assign bus.illegal     = (state == ST_DECODE && !dec_legal) || timeout;
    assign bus.FullOp      = fop_q;
    assign bus.Rdest       = rdest_q;
    assign bus.Rsrc        = rsrc_q;
    assign bus.imm         = imm_q;
    assign bus.ctrlMuxB    = cmux_q;
    assign bus.flags_q     = flags_r;
    assign bus.retired     = retired_q;
endmodule
